ir_prefetch: RTL and testbench



---
 rtl/ir_prefetch.sv | 141 ++++++++++++++
 tb/tb_ir_prefetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ir_prefetch.sv
// Instruction register with a DEPTH-entry prefetch FIFO between instruction memory and control.
// The IR loads the FIFO head in the fetch state; Flush and Reset empty the FIFO and set IR to a NOP.
module ir_prefetch #(
  parameter int                  DATA_W   = 32,
  parameter int                  DEPTH    = 4,
  parameter int                  STATE_W  = 3,
  parameter logic [STATE_W-1:0]  IF_STATE = 3'b000
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [STATE_W-1:0]         state,
  input  logic [DATA_W-1:0]          IDataOut,
  input  logic                       IValid,
  output logic                       IReady,
  input  logic                       Flush,
  input  logic                       ExtSel,
  output logic                       IRValid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic [5:0]                 op,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 sa,
  output logic [5:0]                 funct,
  output logic [15:0]                immediate16,
  output logic [31:0]                immediate32,
  output logic [25:0]                target26
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
    logic [31:0] res;
    if (sign_ext) begin
      res = {{16{imm[15]}}, imm};
    end else begin
      res = {16'h0000, imm};
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [DATA_W-1:0] ir_r, ir_s;
  logic              ir_valid_r, ir_valid_s;
  logic              full_s, empty_s, fetch_s, push_s, pop_s;

  // handshake qualifiers, all taken from registered occupancy
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    fetch_s = (state == IF_STATE);
    push_s  = IValid && !full_s;
    pop_s   = fetch_s && !empty_s;
  end

  // next-state for pointers, occupancy and IR; Flush wins over push and pop
  always_comb begin
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    ir_s       = ir_r;
    ir_valid_s = ir_valid_r;
    if (Flush) begin
      wr_ptr_s   = {PTR_W{1'b0}};
      rd_ptr_s   = {PTR_W{1'b0}};
      count_s    = {CNT_W{1'b0}};
      ir_s       = {DATA_W{1'b0}};
      ir_valid_s = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s   = rd_ptr_r + PTR_W'(1);
        ir_s       = mem_r[rd_ptr_r];
        ir_valid_s = 1'b1;
      end else if (fetch_s) begin
        // empty fetch: stall by dropping IRValid, IR keeps its old word
        ir_s       = ir_r;
        ir_valid_s = 1'b0;
      end else begin
        ir_s       = ir_r;
        ir_valid_s = ir_valid_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_W'(1);
        2'b01:   count_s = count_r - CNT_W'(1);
        default: count_s = count_r;
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ir_r       <= {DATA_W{1'b0}};
      ir_valid_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      ir_r       <= ir_s;
      ir_valid_r <= ir_valid_s;
    end
  end

  // FIFO storage; contents are not cleared, only the pointers are
  always_ff @(posedge CLK) begin
    if (push_s && !Flush && !Reset) begin
      mem_r[wr_ptr_r] <= IDataOut;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // decoded fields are plain slices of the registered IR
  always_comb begin
    IReady      = !full_s;
    IRValid     = ir_valid_r;
    Count       = count_r;
    op          = ir_r[31:26];
    rs          = ir_r[25:21];
    rt          = ir_r[20:16];
    rd          = ir_r[15:11];
    sa          = ir_r[10:6];
    funct       = ir_r[5:0];
    immediate16 = ir_r[15:0];
    immediate32 = extend_imm(ir_r[15:0], ExtSel);
    target26    = ir_r[25:0];
  end

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed bench for ir_prefetch: a queue of accepted words models the FIFO and
// every cycle the IR, IRValid, Count, IReady and decoded fields are compared.
module tb_ir_prefetch;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  state = 3'b000;
  logic [31:0] IDataOut = 32'h0;
  logic        IValid = 1'b0;
  logic        IReady;
  logic        Flush = 1'b0;
  logic        ExtSel = 1'b0;
  logic        IRValid;
  logic [2:0]  Count;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  funct;
  logic [15:0] immediate16;
  logic [31:0] immediate32;
  logic [25:0] target26;

  ir_prefetch #(.DATA_W(32), .DEPTH(4), .STATE_W(3), .IF_STATE(3'b000)) dut (
    .CLK(CLK), .Reset(Reset), .state(state), .IDataOut(IDataOut), .IValid(IValid),
    .IReady(IReady), .Flush(Flush), .ExtSel(ExtSel), .IRValid(IRValid), .Count(Count),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
    .immediate16(immediate16), .immediate32(immediate32), .target26(target26)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] m_ir = 32'h0;
  logic        m_irv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ext;
    ext = ExtSel ? {{16{m_ir[15]}}, m_ir[15:0]} : {16'h0000, m_ir[15:0]};
    chk({tag, ".ir"},      {op, rs, rt, rd, sa, funct}, m_ir);
    chk({tag, ".irvalid"}, 32'(IRValid), 32'(m_irv));
    chk({tag, ".count"},   32'(Count), 32'(sb.size()));
    chk({tag, ".iready"},  32'(IReady), 32'(sb.size() < 4));
    chk({tag, ".target"},  32'(target26), 32'(m_ir[25:0]));
    chk({tag, ".imm32"},   immediate32, ext);
  endtask

  // one clock: drive inputs, advance the model with pre-edge values, compare after the edge
  task automatic step(input string tag, input logic iv, input logic [31:0] d,
                      input logic [2:0] st, input logic fl, input logic rst);
    logic do_push, do_pop;
    IValid = iv; IDataOut = d; state = st; Flush = fl; Reset = rst;
    do_push = iv && (sb.size() < 4);
    do_pop  = (st == 3'b000) && (sb.size() != 0);
    if (rst || fl) begin
      sb.delete();
      m_ir  = 32'h0;
      m_irv = 1'b0;
    end else begin
      if (do_pop) begin
        m_ir  = sb.pop_front();
        m_irv = 1'b1;
      end else if (st == 3'b000) begin
        m_irv = 1'b0;
      end
      if (do_push) sb.push_back(d);
    end
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // reset held two cycles while a push and a fetch are requested
    step("reset0", 1'b1, 32'hDEADBEEF, 3'b000, 1'b0, 1'b1);
    step("reset1", 1'b1, 32'hDEADBEEF, 3'b000, 1'b0, 1'b1);
    chk("reset.op_const", 32'(op), 32'h0);
    chk("reset.count_const", 32'(Count), 32'h0);

    // push-to-IR latency with lw $2,4($1)
    step("lat.push", 1'b1, 32'h8C220004, 3'b001, 1'b0, 1'b0);
    step("lat.load", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("lat.op", 32'(op), 32'h23);
    chk("lat.rs", 32'(rs), 32'h1);
    chk("lat.rt", 32'(rt), 32'h2);
    chk("lat.imm16", 32'(immediate16), 32'h0004);
    chk("lat.irvalid", 32'(IRValid), 32'h1);
    chk("lat.count", 32'(Count), 32'h0);

    // fill: fifth word must be refused
    for (int i = 0; i < 5; i++) begin
      step("full.push", 1'b1, 32'h11110000 + 32'(i), 3'b010, 1'b0, 1'b0);
      if (i == 3) begin
        chk("full.count4", 32'(Count), 32'h4);
        chk("full.iready0", 32'(IReady), 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step("full.load", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
      chk("full.order", {op, rs, rt, rd, sa, funct}, 32'h11110000 + 32'(i));
    end
    chk("full.drained", 32'(Count), 32'h0);

    // empty fetch stalls and holds IR
    step("empty0", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step("empty1", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("empty.ir_hold", {op, rs, rt, rd, sa, funct}, 32'h11110003);
    chk("empty.irvalid", 32'(IRValid), 32'h0);

    // flush collides with push and fetch
    step("fl.push0", 1'b1, 32'hAAAA0001, 3'b011, 1'b0, 1'b0);
    step("fl.push1", 1'b1, 32'hAAAA0002, 3'b011, 1'b0, 1'b0);
    step("fl.hit", 1'b1, 32'hAAAA0003, 3'b000, 1'b1, 1'b0);
    chk("fl.ir_nop", {op, rs, rt, rd, sa, funct}, 32'h0);
    chk("fl.count", 32'(Count), 32'h0);
    step("fl.push2", 1'b1, 32'hBBBB0004, 3'b011, 1'b0, 1'b0);
    step("fl.load", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("fl.next_word", {op, rs, rt, rd, sa, funct}, 32'hBBBB0004);

    // immediate extension follows ExtSel combinationally
    step("ext.push", 1'b1, 32'h2001FFFF, 3'b100, 1'b0, 1'b0);
    step("ext.load", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    ExtSel = 1'b1;
    #1;
    chk("ext.sign", immediate32, 32'hFFFFFFFF);
    ExtSel = 1'b0;
    #1;
    chk("ext.zero", immediate32, 32'h0000FFFF);
    ExtSel = 1'b1;

    // streaming push+pop across several pointer wraps
    step("wrap.first", 1'b1, 32'hC0DE0000, 3'b001, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) begin
      step("wrap.stream", 1'b1, 32'hC0DE0000 + 32'(i), 3'b000, 1'b0, 1'b0);
      chk("wrap.inorder", {op, rs, rt, rd, sa, funct}, 32'hC0DE0000 + 32'(i - 1));
    end
    step("wrap.drain", 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    chk("wrap.last", {op, rs, rt, rd, sa, funct}, 32'hC0DE000B);
    chk("wrap.empty", 32'(Count), 32'h0);

    // reset mid-operation cancels push and load
    step("rmid.push", 1'b1, 32'h12345678, 3'b001, 1'b0, 1'b0);
    step("rmid.rst", 1'b1, 32'h87654321, 3'b000, 1'b1, 1'b1);
    chk("rmid.ir", {op, rs, rt, rd, sa, funct}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
